// File: rtl/washer_pkg.sv
// Shared types for the wash-program sequencer: state encodings and the
// phase-to-Timer-done mapping.
package washer_pkg;

  localparam int unsigned STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    SPIN  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DONE_1U = 2'd0,
    DONE_2U = 2'd1,
    DONE_5U = 2'd2
  } done_sel_t;

  // Which Timer done pulse closes each timed phase
  localparam done_sel_t FILL_DONE  = DONE_1U;
  localparam done_sel_t WASH_DONE  = DONE_5U;
  localparam done_sel_t RINSE_DONE = DONE_2U;
  localparam done_sel_t SPIN_DONE  = DONE_1U;

  function automatic logic done_hit(input done_sel_t sel, input logic d1,
                                    input logic d2, input logic d5);
    logic hit;
    hit = 1'b0;
    case (sel)
      DONE_1U: hit = d1;
      DONE_2U: hit = d2;
      DONE_5U: hit = d5;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/washer_cycle_ctrl.sv
// Wash-program sequencer: steps FILL/WASH/RINSE/SPIN timed by the sibling
// Timer, drives actuators, handles pause, door fault, cancel and double wash.
module washer_cycle_ctrl
  import washer_pkg::*;
#(
  parameter bit          DOUBLE_EN = 1'b1,
  parameter int unsigned STATE_W   = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               coin_in,
  input  logic               double_wash,
  input  logic               door_closed,
  input  logic               pause,
  input  logic               cancel,
  input  logic               done1u,
  input  logic               done2u,
  input  logic               done5u,
  output logic               timer_stop,
  output logic               timer_clr_n,
  output logic               water_valve,
  output logic               motor_wash,
  output logic               motor_spin,
  output logic               drain_pump,
  output logic               door_lock,
  output logic               wash_done,
  output logic [STATE_W-1:0] state_o
);

  state_t state_q, state_d;
  logic   dw_pend_q, dw_pend_d;
  logic   wash_done_d;
  logic   stalled_c;
  logic   done_ok_c;

  assign stalled_c = (state_q != IDLE) && (pause || !door_closed);
  // Done pulses are stale during the clear cycle and frozen while stalled
  assign done_ok_c = timer_clr_n && !stalled_c;
  assign state_o   = STATE_W'(state_q);

  // State and registered outputs; a state change yields one Timer clear cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dw_pend_q   <= 1'b0;
      wash_done   <= 1'b0;
      timer_clr_n <= 1'b1;
    end else begin
      state_q     <= state_d;
      dw_pend_q   <= dw_pend_d;
      wash_done   <= wash_done_d;
      timer_clr_n <= (state_d == state_q);
    end
  end

  // Next state and actuator decode
  always_comb begin
    state_d     = state_q;
    dw_pend_d   = dw_pend_q;
    wash_done_d = 1'b0;
    water_valve = 1'b0;
    motor_wash  = 1'b0;
    motor_spin  = 1'b0;
    drain_pump  = 1'b0;
    door_lock   = (state_q != IDLE);
    timer_stop  = (state_q == IDLE) || stalled_c;

    case (state_q)
      IDLE: begin
        if (coin_in && door_closed) begin
          state_d   = FILL;
          dw_pend_d = double_wash & DOUBLE_EN;
        end
      end
      FILL: begin
        if (cancel) begin
          state_d   = SPIN;
          dw_pend_d = 1'b0;
        end else if (done_ok_c && done_hit(FILL_DONE, done1u, done2u, done5u)) begin
          state_d = WASH;
        end
      end
      WASH: begin
        if (cancel) begin
          state_d   = SPIN;
          dw_pend_d = 1'b0;
        end else if (done_ok_c && done_hit(WASH_DONE, done1u, done2u, done5u)) begin
          state_d = RINSE;
        end
      end
      RINSE: begin
        if (cancel) begin
          state_d   = SPIN;
          dw_pend_d = 1'b0;
        end else if (done_ok_c && done_hit(RINSE_DONE, done1u, done2u, done5u)) begin
          state_d   = dw_pend_q ? FILL : SPIN;
          dw_pend_d = 1'b0;
        end
      end
      SPIN: begin
        if (done_ok_c && done_hit(SPIN_DONE, done1u, done2u, done5u)) begin
          state_d     = IDLE;
          wash_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!stalled_c) begin
      case (state_q)
        FILL:  water_valve = 1'b1;
        WASH:  motor_wash  = 1'b1;
        RINSE: begin
          water_valve = 1'b1;
          motor_wash  = 1'b1;
        end
        SPIN: begin
          drain_pump = 1'b1;
          motor_spin = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_washer_cycle_ctrl.sv
// Scoreboard bench for washer_cycle_ctrl with a Timer model; expected state
// change times are computed from phase lengths plus stall cycles.
`timescale 1ns/1ps
module tb_washer_cycle_ctrl;
  import washer_pkg::*;

  logic clk = 1'b0, reset_n = 1'b0, coin_in = 1'b0, double_wash = 1'b0;
  logic door_closed = 1'b1, pause = 1'b0, cancel = 1'b0;
  logic done1u, done2u, done5u;
  logic timer_stop, timer_clr_n, water_valve, motor_wash, motor_spin;
  logic drain_pump, door_lock, wash_done;
  logic [2:0] state_o;

  int unsigned cyc = 0;
  int unsigned total = 0, bad = 0;
  int unsigned tcnt = 0;
  logic force_d5 = 1'b0;
  bit in_force = 1'b0;

  typedef struct {int unsigned cyc; logic [2:0] st;} ev_t;
  ev_t st_q[$];
  int unsigned wd_q[$];

  int unsigned p_s[7], p_off[7];
  bit p_door[7], p_coin[7];

  washer_cycle_ctrl #(.DOUBLE_EN(1'b1), .STATE_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .coin_in(coin_in), .double_wash(double_wash),
    .door_closed(door_closed), .pause(pause), .cancel(cancel),
    .done1u(done1u), .done2u(done2u), .done5u(done5u),
    .timer_stop(timer_stop), .timer_clr_n(timer_clr_n), .water_valve(water_valve),
    .motor_wash(motor_wash), .motor_spin(motor_spin), .drain_pump(drain_pump),
    .door_lock(door_lock), .wash_done(wash_done), .state_o(state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Timer model: clear wins, freezes on stop, counts 0..499
  always @(posedge clk) begin
    if (!(reset_n && timer_clr_n)) tcnt <= 0;
    else if (!timer_stop) tcnt <= (tcnt == 499) ? 0 : tcnt + 1;
  end
  assign done1u = (tcnt == 99);
  assign done2u = (tcnt == 199);
  assign done5u = (tcnt == 499) || force_d5;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push_st(input int unsigned c, input logic [2:0] s);
    ev_t ev;
    ev.cyc = c; ev.st = s;
    st_q.push_back(ev);
  endtask

  // Expected actuators {valve, agitate, spin, pump, lock} from the phase table
  function automatic logic [4:0] exp_act(input logic [2:0] st, input logic stl);
    logic [3:0] a;
    case (st)
      3'd1:    a = 4'b1000;
      3'd2:    a = 4'b0100;
      3'd3:    a = 4'b1100;
      3'd4:    a = 4'b0011;
      default: a = 4'b0000;
    endcase
    if (stl) a = 4'b0000;
    return {a, st != 3'd0};
  endfunction

  function automatic logic [2:0] phase_at(input int i, input bit dw);
    if ((!dw && i == 3) || i == 6) return 3'd4;
    case (i % 3)
      0:       return 3'd1;
      1:       return 3'd2;
      default: return 3'd3;
    endcase
  endfunction

  // Phase residency = 100 * units + 1 cycles
  function automatic int unsigned base_of(input logic [2:0] ph);
    case (ph)
      3'd2:    return 5 * 100 + 1;
      3'd3:    return 2 * 100 + 1;
      default: return 1 * 100 + 1;
    endcase
  endfunction

  // Monitor: pops expectations when the DUT changes state or pulses wash_done
  logic [2:0] m_prev_st = 3'd0;
  logic       m_prev_rst = 1'b0;
  initial begin : monitor
    ev_t ev;
    logic stl;
    forever begin
      @(negedge clk);
      if (state_o !== m_prev_st) begin
        if (st_q.size() == 0) begin
          total++; bad++;
          $display("FAIL state_unexpected: got %0d want no change (cycle %0d)", state_o, cyc);
        end else begin
          ev = st_q.pop_front();
          check("state_val", state_o, ev.st);
          check("state_cyc", cyc, ev.cyc);
        end
      end
      if (wash_done === 1'b1) begin
        if (wd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wash_done_unexpected: got 1 want 0 (cycle %0d)", cyc);
        end else check("wash_done_cyc", cyc, wd_q.pop_front());
      end
      if (!in_force)
        check("timer_clr_n", timer_clr_n, (m_prev_rst && state_o != m_prev_st) ? 0 : 1);
      stl = (state_o != 3'd0) && (pause || !door_closed);
      check("timer_stop", timer_stop, (state_o == 3'd0) || stl);
      check("actuators", {water_valve, motor_wash, motor_spin, drain_pump, door_lock},
            exp_act(state_o, stl));
      m_prev_st  = state_o;
      m_prev_rst = reset_n;
    end
  end

  task automatic clear_plan();
    for (int i = 0; i < 7; i++) begin
      p_s[i] = 0; p_off[i] = 0; p_door[i] = 1'b0; p_coin[i] = 1'b0;
    end
  endtask

  task automatic rand_plan();
    for (int i = 0; i < 7; i++) begin
      p_s[i]    = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 25);
      p_off[i]  = $urandom_range(10, 60);
      p_door[i] = 1'($urandom_range(0, 1));
      p_coin[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // Issue one program; expectations pushed up front, stimulus follows the plan
  task automatic run_program(input bit dw);
    int unsigned e, t, n, dur;
    n = dw ? 7 : 4;
    coin_in = 1'b1; double_wash = dw; e = cyc + 1;
    t = e;
    for (int i = 0; i < n; i++) begin
      push_st(t, phase_at(i, dw));
      t += base_of(phase_at(i, dw)) + p_s[i];
    end
    push_st(t, 3'd0);
    wd_q.push_back(t);
    tick(1);
    coin_in = 1'b0; double_wash = 1'($urandom);
    t = e;
    for (int i = 0; i < n; i++) begin
      dur = base_of(phase_at(i, dw)) + p_s[i];
      if (p_s[i] != 0) begin
        tick(int'(t + p_off[i] - cyc));
        if (p_door[i]) door_closed = 1'b0; else pause = 1'b1;
        tick(int'(p_s[i]));
        door_closed = 1'b1; pause = 1'b0;
      end
      if (p_coin[i]) begin
        coin_in = 1'b1; double_wash = 1'($urandom);
        tick(1);
        coin_in = 1'b0;
      end
      tick(int'(t + dur - cyc));
      t += dur;
    end
    tick(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, state_o, 0);
    check({tag, "_clr_n"}, timer_clr_n, 1);
    check({tag, "_wash_done"}, wash_done, 0);
    check({tag, "_timer_stop"}, timer_stop, 1);
    check({tag, "_acts"}, {water_valve, motor_wash, motor_spin, drain_pump, door_lock}, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned e, w, s, r;
    tick(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    tick(2);

    clear_plan(); run_program(1'b0);
    clear_plan(); run_program(1'b1);
    clear_plan();
    p_off[1] = 200; p_s[1] = 50;
    p_off[2] = 100; p_s[2] = 10; p_door[2] = 1'b1;
    run_program(1'b0);
    clear_plan(); p_off[1] = 500; p_s[1] = 20;
    run_program(1'b0);

    // Cancel in WASH at count 200 alongside a forced done5u
    coin_in = 1'b1; double_wash = 1'b1; e = cyc + 1;
    w = e + 101; s = w + 202;
    push_st(e, 3'd1); push_st(w, 3'd2); push_st(s, 3'd4); push_st(s + 101, 3'd0);
    wd_q.push_back(s + 101);
    tick(1); coin_in = 1'b0;
    tick(int'(w + 201 - cyc));
    cancel = 1'b1; force_d5 = 1'b1;
    tick(1);
    cancel = 1'b0; force_d5 = 1'b0;
    tick(30);
    cancel = 1'b1; coin_in = 1'b1;
    tick(1);
    cancel = 1'b0; coin_in = 1'b0;
    tick(int'(s + 101 - cyc) + 2);
    cancel = 1'b1; tick(1); cancel = 1'b0;
    tick(3);
    check("cancel_idle_ignored", state_o, 0);

    // Coin with door open is dropped
    door_closed = 1'b0; coin_in = 1'b1;
    tick(1);
    coin_in = 1'b0; door_closed = 1'b1;
    tick(2);
    check("coin_door_open", state_o, 0);

    // Reset mid-RINSE
    coin_in = 1'b1; double_wash = 1'b0; e = cyc + 1;
    r = e + 101 + 501;
    push_st(e, 3'd1); push_st(e + 101, 3'd2); push_st(r, 3'd3); push_st(r + 51, 3'd0);
    tick(1); coin_in = 1'b0;
    tick(int'(r + 50 - cyc));
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check_reset_outputs("midreset");
    tick(3);

    // Illegal state 6 returns to IDLE on the next edge
    @(negedge clk); #1;
    in_force = 1'b1;
    force dut.state_q = state_t'(3'd6);
    #1 release dut.state_q;
    check("illegal_seen", state_o, 6);
    @(posedge clk); #1;
    check("illegal_to_idle", state_o, 0);
    check("illegal_clr_n", timer_clr_n, 0);
    tick(1);
    in_force = 1'b0;
    tick(2);

    repeat (4) begin
      rand_plan();
      run_program(1'($urandom_range(0, 1)));
    end

    tick(3);
    check("state_queue_drained", st_q.size(), 0);
    check("wash_done_queue_drained", wd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
